// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, line levels, legal
// oversampling factors and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam int UART_PRESC_8  = 8;
    localparam int UART_PRESC_16 = 16;
    localparam int UART_PRESC_32 = 32;

    // Callers zero-extend their data word to this width.
    localparam int UART_MAX_W = 32;

    // typ = 0 gives even parity, typ = 1 gives odd parity.
    function automatic logic parity_bit(input logic [UART_MAX_W-1:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a 2-of-3 majority vote around mid-bit.
// vote_o is valid while sample_done_o is high; bit_end_o marks the last cycle of a bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               rx_i,
    output logic               vote_o,
    output logic               sample_done_o,
    output logic               bit_end_o
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESC_W-1:0] half;
    logic               s0_q, s1_q;

    assign half          = prescale_i >> 1;
    assign bit_end_o     = en_i && (edge_cnt_q == prescale_i - PRESC_W'(1));
    assign sample_done_o = en_i && (edge_cnt_q == half + PRESC_W'(1));
    // Third sample is the live input, so the decision lands on the P/2+1 cycle.
    assign vote_o        = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);

    always_comb begin
        edge_cnt_d = '0;
        if (en_i && !bit_end_o)
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            s0_q       <= UART_IDLE_LVL;
            s1_q       <= UART_IDLE_LVL;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (en_i && edge_cnt_q == half - PRESC_W'(1))
                s0_q <= rx_i;
            if (en_i && edge_cnt_q == half)
                s1_q <= rx_i;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// Oversampled UART receiver: start, DATA_W bits LSB-first, optional parity, one stop bit.
// Define UART_RX_SYNC_EN to pass RX_IN_S through a 2-flop synchronizer (+2 cycles latency).
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               RX_CLK,
    input  logic               RST,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               RX_IN_S,
    output logic [DATA_W-1:0]  RX_OUT_P,
    output logic               RX_OUT_V,
    output logic               PAR_ERR,
    output logic               STP_ERR,
    output logic               RX_BUSY
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_state_e        state_q;
    logic [PRESC_W-1:0] presc_q;
    logic               par_en_q, par_typ_q, par_bad_q;
    logic [BCW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0]  shift_q, out_p_q;
    logic               out_v_q, par_err_q, stp_err_q;
    logic               rx, vote, sample_done, bit_end;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge RX_CLK) begin
        if (RST) sync_q <= {2{UART_IDLE_LVL}};
        else     sync_q <= {sync_q[0], RX_IN_S};
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN_S;
`endif

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk_i         (RX_CLK),
        .rst_i         (RST),
        .en_i          (state_q != ST_IDLE),
        .prescale_i    (presc_q),
        .rx_i          (rx),
        .vote_o        (vote),
        .sample_done_o (sample_done),
        .bit_end_o     (bit_end)
    );

    always_ff @(posedge RX_CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            out_p_q   <= '0;
            out_v_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            out_v_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Frame configuration is frozen here for the whole frame.
                    if (rx == UART_START_LVL) begin
                        state_q   <= ST_START;
                        presc_q   <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (sample_done && vote == UART_IDLE_LVL)
                        state_q <= ST_IDLE;
                    else if (bit_end)
                        state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (sample_done)
                        shift_q[bit_cnt_q] <= vote;
                    if (bit_end) begin
                        if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_done)
                        par_bad_q <= (vote != parity_bit(UART_MAX_W'(shift_q), par_typ_q));
                    if (bit_end)
                        state_q <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at the vote so a back-to-back start edge is not missed.
                    if (sample_done) begin
                        state_q <= ST_IDLE;
                        if (vote != UART_IDLE_LVL) begin
                            stp_err_q <= 1'b1;
                            par_err_q <= par_bad_q;
                        end else if (par_bad_q) begin
                            par_err_q <= 1'b1;
                        end else begin
                            out_p_q <= shift_q;
                            out_v_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RX_OUT_P = out_p_q;
    assign RX_OUT_V = out_v_q;
    assign PAR_ERR  = par_err_q;
    assign STP_ERR  = stp_err_q;
    assign RX_BUSY  = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Oversampled UART receiver that deframes a serial stream back into parallel bytes. Frame format: start bit (0), 8 data bits LSB-first, optional parity bit, one stop bit (1). It is the receive end for the existing serial transmit path, and it flags parity and stop-bit errors.

Parameters:
DATA_W, 8, data bits per frame
PRESC_W, 6, width of Prescale input

Ports:
RX_CLK  input  1  receive oversampling clock, Prescale cycles per bit
RST  input  1  synchronous, active-high reset
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESC_W  oversampling factor; legal values 8, 16, 32
RX_IN_S  input  1  serial line, idles high
RX_OUT_P  output  DATA_W  last correctly received byte
RX_OUT_V  output  1  one-cycle pulse when RX_OUT_P is updated
PAR_ERR  output  1  one-cycle pulse on parity mismatch
STP_ERR  output  1  one-cycle pulse when stop bit is sampled 0
RX_BUSY  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock is RX_CLK. Reset is synchronous, active-high: RST=1 at a rising RX_CLK edge clears everything.
- Reset values: RX_OUT_P=0, RX_OUT_V=0, PAR_ERR=0, STP_ERR=0, RX_BUSY=0, FSM=IDLE, all counters 0. Reset mid-frame abandons the frame with no pulses.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit.
  - bit_cnt runs 0..DATA_W-1 during DATA.
- Sampling: majority vote (2 of 3) over the RX_IN_S values at edge_cnt = P/2-1, P/2, P/2+1, where P = Prescale. The bit decision is available at edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN_S=0 → START with edge_cnt=0. Latch PAR_EN, PAR_TYP and Prescale at this point; mid-frame changes are ignored.
  - START: vote=1 (glitch) → IDLE, no outputs. Otherwise, at edge_cnt=P-1 → DATA.
  - DATA: shift the vote into bit position bit_cnt (LSB first). At edge_cnt=P-1 with bit_cnt=DATA_W-1 → PARITY if the latched PAR_EN=1, else STOP.
  - PARITY: expected bit = XOR(data) XOR PAR_TYP. Store the mismatch flag; at edge_cnt=P-1 → STOP.
  - STOP: at the vote point (edge_cnt=P/2+1), go to IDLE immediately; the second half of the stop bit is skipped so back-to-back frames work.
- Outputs, on the cycle after the stop vote (registered):
  - Stop vote=0: STP_ERR pulses. If a parity mismatch was also stored, PAR_ERR pulses in the same cycle.
  - Stop vote=1 with parity mismatch: PAR_ERR pulses.
  - Otherwise: RX_OUT_P ← shifted byte, RX_OUT_V pulses for 1 cycle.
  - On any error the byte is discarded and RX_OUT_P keeps its previous value.
- Latency: RX_OUT_V rises (9+PAR_EN)·P + P/2 + 2 cycles after the cycle in which the start falling edge is seen in IDLE. For P=8 with no parity this is 78 cycles.
- A new falling edge seen in IDLE on the cycle right after the STOP→IDLE transition is accepted.
- Prescale values outside {8,16,32}: behaviour is undefined; verification does not exercise them.

Optional Feature:
UART_RX_SYNC_EN
- Defined: RX_IN_S passes through a 2-flop synchronizer (reset to 1) before edge detection and sampling. All latencies grow by 2 cycles (P=8, no parity: 80).
- Undefined: RX_IN_S is used directly; the source must already be synchronous to RX_CLK.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - constants UART_IDLE_LVL=1, UART_START_LVL=0
  - legal prescale constants 8/16/32
  - a parity function parity_bit(data, typ)
- One sub-module, uart_rx_sampler: contains edge_cnt, the 3-sample majority vote, and a sample_done strobe. It is reused by the deframer FSM.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 (framed) → one RX_OUT_V pulse 78 cycles after the start edge, RX_OUT_P=0xA5, no errors.
- P=8, PAR_EN=1, PAR_TYP=0, send 0x55 with parity bit 0 → RX_OUT_P=0x55, RX_OUT_V=1. Repeat with parity bit forced 1 → PAR_ERR pulse, RX_OUT_P stays 0x55 (expected 0x55 here; 0xA5 only if run standalone after the first test).
- P=16, PAR_EN=1, PAR_TYP=1, send 0xFF with parity bit 1 → RX_OUT_P=0xFF. Stop bit forced 0 → STP_ERR pulse, no RX_OUT_V.
- RX_IN_S low for 2 cycles only, P=8 → FSM returns to IDLE, no pulses, RX_BUSY low within P/2+2 cycles.
- Back-to-back frames 0x12, 0x34 with no idle gap, P=32 → two RX_OUT_V pulses, values 0x12 then 0x34.
- RST=1 asserted in the middle of DATA bit 4 → all outputs 0 on the next cycle; a following valid frame 0x3C is received correctly.
